// File: rtl/int_rti_sequencer_pkg.sv
// Shared definitions for the INT/RTI sequencer: FSM state encoding, stack-pointer
// control codes and the CCR flag layout {OVF,Z,N,C}.
package int_rti_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DRAIN   = 4'd1,
    PUSH_HI = 4'd2,
    PUSH_LO = 4'd3,
    PUSH_F  = 4'd4,
    VEC_LO  = 4'd5,
    VEC_HI  = 4'd6,
    JUMP    = 4'd7,
    R_FLAGS = 4'd8,
    R_LO    = 4'd9,
    R_HI    = 4'd10,
    R_JUMP  = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_PUSH = 2'd1,
    SP_POP  = 2'd2
  } sp_src_e;

  typedef struct packed {
    logic ovf;
    logic z;
    logic n;
    logic c;
  } flags_t;

  // Flags travel through the stack as the low nibble of a 16-bit word.
  function automatic logic [15:0] flags_word(input flags_t f);
    return {12'b0, f};
  endfunction

endpackage

// File: rtl/sequencer_drain_counter.sv
// Up-counter that measures the pipeline drain window; tc_o fires on the last
// enabled cycle and the count wraps to zero on that same edge.
module sequencer_drain_counter #(
  parameter int CNT_W    = 2,
  parameter int TERMINAL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == TC_VAL);

  always_comb begin
    // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
    count_d = count_q;
    if (clr_i || tc_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/int_rti_sequencer.sv
// Multi-cycle INT/RTI controller: drives the shared EX/MEM datapath to push or pop
// the return PC and CCR flags and redirects the PC through the vector or the stack.
module int_rti_sequencer
  import int_rti_sequencer_pkg::*;
#(
  parameter logic [15:0] VEC_ADDR     = 16'h0000,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        rti_in,
  input  logic        do_jmp_in,
  input  logic [31:0] ret_pc_in,
  input  logic [3:0]  flags_in,
  input  logic [15:0] mem_rdata_in,
  output logic        stall_fetch_out,
  output logic        flush_out,
  output logic        mem_write_out,
  output logic        mem_read_out,
  output logic        mem_addr_src_out,
  output logic [15:0] mem_addr_out,
  output logic [15:0] mem_wdata_out,
  output logic [1:0]  SP_src_out,
  output logic        PC_load_out,
  output logic [31:0] PC_load_val_out,
  output logic        is_POP_flags_out,
  output logic [3:0]  POP_flags_val_out,
  output logic        stall_CCR_POP_out,
  output logic        busy_out
);

  // Second vector word; 16-bit arithmetic wraps FFFF to 0000.
  localparam logic [15:0] VEC_ADDR_HI = VEC_ADDR + 16'd1;

  state_e      state_q, state_d;
  logic [27:0] ret_pc_q, ret_pc_d;
  flags_t      flags_q, flags_d;
  logic [15:0] lo_q, lo_d;
  logic        drain_done;

  // Only 28 PC bits are architectural; the top nibble is dropped on capture.
  logic unused_pc_bits;
  assign unused_pc_bits = ^ret_pc_in[31:28];

  sequencer_drain_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (DRAIN_CYCLES - 1)
  ) u_drain_counter (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (state_q == DRAIN),
    .clr_i (state_q != DRAIN),
    .tc_o  (drain_done)
  );

  always_comb begin
    state_d           = state_q;
    ret_pc_d          = ret_pc_q;
    flags_d           = flags_q;
    lo_d              = lo_q;
    stall_fetch_out   = 1'b0;
    stall_CCR_POP_out = 1'b0;
    flush_out         = 1'b0;
    mem_write_out     = 1'b0;
    mem_read_out      = 1'b0;
    mem_addr_src_out  = 1'b0;
    mem_addr_out      = '0;
    mem_wdata_out     = '0;
    SP_src_out        = SP_HOLD;
    PC_load_out       = 1'b0;
    PC_load_val_out   = '0;
    is_POP_flags_out  = 1'b0;
    POP_flags_val_out = '0;
    busy_out          = (state_q != IDLE);

    if (state_q != IDLE) begin
      stall_fetch_out   = 1'b1;
      stall_CCR_POP_out = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (rti_in) begin
          state_d = R_FLAGS;
        end else if (int_req && !do_jmp_in) begin
          ret_pc_d = ret_pc_in[27:0];
          flags_d  = flags_t'(flags_in);
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        mem_write_out = 1'b1;
        SP_src_out    = SP_PUSH;
        mem_wdata_out = {4'b0000, ret_pc_q[27:16]};
        state_d       = PUSH_LO;
      end
      PUSH_LO: begin
        mem_write_out = 1'b1;
        SP_src_out    = SP_PUSH;
        mem_wdata_out = ret_pc_q[15:0];
        state_d       = PUSH_F;
      end
      PUSH_F: begin
        mem_write_out = 1'b1;
        SP_src_out    = SP_PUSH;
        mem_wdata_out = flags_word(flags_q);
        state_d       = VEC_LO;
      end
      VEC_LO: begin
        mem_read_out     = 1'b1;
        mem_addr_src_out = 1'b1;
        mem_addr_out     = VEC_ADDR;
        state_d          = VEC_HI;
      end
      VEC_HI: begin
        lo_d             = mem_rdata_in;
        mem_read_out     = 1'b1;
        mem_addr_src_out = 1'b1;
        mem_addr_out     = VEC_ADDR_HI;
        state_d          = JUMP;
      end
      JUMP: begin
        PC_load_out     = 1'b1;
        PC_load_val_out = {mem_rdata_in, lo_q};
        flush_out       = 1'b1;
        state_d         = IDLE;
      end
      R_FLAGS: begin
        mem_read_out = 1'b1;
        SP_src_out   = SP_POP;
        state_d      = R_LO;
      end
      R_LO: begin
        // The popped flags own the CCR this cycle, so the ALU hold is released.
        stall_CCR_POP_out = 1'b0;
        is_POP_flags_out  = 1'b1;
        POP_flags_val_out = mem_rdata_in[3:0];
        mem_read_out      = 1'b1;
        SP_src_out        = SP_POP;
        state_d           = R_HI;
      end
      R_HI: begin
        lo_d         = mem_rdata_in;
        mem_read_out = 1'b1;
        SP_src_out   = SP_POP;
        state_d      = R_JUMP;
      end
      R_JUMP: begin
        PC_load_out     = 1'b1;
        PC_load_val_out = {mem_rdata_in, lo_q};
        flush_out       = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ret_pc_q <= '0;
      flags_q  <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      ret_pc_q <= ret_pc_d;
      flags_q  <= flags_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_int_rti_sequencer.sv
// Directed bench for int_rti_sequencer with a small stack/vector memory model;
// a second instance with VEC_ADDR=FFFF covers vector address wrap.
module tb_int_rti_sequencer;

  localparam int DRAIN_CYCLES = 3;
  localparam int INT_LAT      = 1 + DRAIN_CYCLES + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        int_req = 1'b0, rti_in = 1'b0, do_jmp_in = 1'b0;
  logic [31:0] ret_pc_in = '0;
  logic [3:0]  flags_in = '0;
  logic [15:0] mem_rdata_in = '0;

  logic        stall_fetch_out, flush_out, mem_write_out, mem_read_out, mem_addr_src_out;
  logic [15:0] mem_addr_out, mem_wdata_out;
  logic [1:0]  SP_src_out;
  logic        PC_load_out;
  logic [31:0] PC_load_val_out;
  logic        is_POP_flags_out;
  logic [3:0]  POP_flags_val_out;
  logic        stall_CCR_POP_out, busy_out;

  logic        stall_fetch_w, flush_w, mem_write_w, mem_read_w, mem_addr_src_w;
  logic [15:0] mem_addr_w, mem_wdata_w;
  logic [1:0]  SP_src_w;
  logic        PC_load_w;
  logic [31:0] PC_load_val_w;
  logic        is_POP_flags_w;
  logic [3:0]  POP_flags_val_w;
  logic        stall_CCR_POP_w, busy_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_rti_sequencer #(.VEC_ADDR(16'h0000), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .rti_in(rti_in), .do_jmp_in(do_jmp_in),
    .ret_pc_in(ret_pc_in), .flags_in(flags_in), .mem_rdata_in(mem_rdata_in),
    .stall_fetch_out(stall_fetch_out), .flush_out(flush_out), .mem_write_out(mem_write_out),
    .mem_read_out(mem_read_out), .mem_addr_src_out(mem_addr_src_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .SP_src_out(SP_src_out), .PC_load_out(PC_load_out),
    .PC_load_val_out(PC_load_val_out), .is_POP_flags_out(is_POP_flags_out),
    .POP_flags_val_out(POP_flags_val_out), .stall_CCR_POP_out(stall_CCR_POP_out),
    .busy_out(busy_out)
  );

  int_rti_sequencer #(.VEC_ADDR(16'hFFFF), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .int_req(int_req), .rti_in(rti_in), .do_jmp_in(do_jmp_in),
    .ret_pc_in(ret_pc_in), .flags_in(flags_in), .mem_rdata_in(mem_rdata_in),
    .stall_fetch_out(stall_fetch_w), .flush_out(flush_w), .mem_write_out(mem_write_w),
    .mem_read_out(mem_read_w), .mem_addr_src_out(mem_addr_src_w), .mem_addr_out(mem_addr_w),
    .mem_wdata_out(mem_wdata_w), .SP_src_out(SP_src_w), .PC_load_out(PC_load_w),
    .PC_load_val_out(PC_load_val_w), .is_POP_flags_out(is_POP_flags_w),
    .POP_flags_val_out(POP_flags_val_w), .stall_CCR_POP_out(stall_CCR_POP_w),
    .busy_out(busy_w)
  );

  logic [78:0] all_out;
  assign all_out = {stall_fetch_out, flush_out, mem_write_out, mem_read_out, mem_addr_src_out,
                    mem_addr_out, mem_wdata_out, SP_src_out, PC_load_out, PC_load_val_out,
                    is_POP_flags_out, POP_flags_val_out, stall_CCR_POP_out, busy_out};

  // Memory model: SP pre-decrements on push, post-increments on pop; read data
  // appears one cycle after the read strobe.
  logic [15:0] stack_mem [0:31];
  int          sp = 16;
  logic [15:0] pend_rd = '0;
  logic [15:0] push_log [$];
  logic [15:0] rd_addr_w [$];

  function automatic logic [15:0] vec_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0200;
    if (a == 16'h0001) return 16'h0001;
    return 16'hDEAD;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (mem_write_out && SP_src_out == 2'd1) begin
        sp = (sp - 1) & 31;
        stack_mem[sp] = mem_wdata_out;
        push_log.push_back(mem_wdata_out);
      end
      if (mem_read_out) begin
        if (mem_addr_src_out) begin
          pend_rd = vec_word(mem_addr_out);
        end else begin
          pend_rd = stack_mem[sp];
          if (SP_src_out == 2'd2) sp = (sp + 1) & 31;
        end
      end
      if (mem_read_w && mem_addr_src_w) rd_addr_w.push_back(mem_addr_w);
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata_in = pend_rd;
  end

  // Runs one interrupt from acceptance to PC load; lat counts the accept cycle as 1.
  task automatic run_int(input logic [31:0] pc, input logic [3:0] fl, input bit pulse_rti,
                         output int lat, output logic [31:0] pc_val, output logic fl_seen,
                         output logic [2:0] drain_sig);
    int  writes_seen;
    bit  done;
    writes_seen = 0;
    done        = 0;
    pc_val      = '0;
    fl_seen     = 1'b0;
    drain_sig   = '0;
    @(negedge clk);
    ret_pc_in = pc;
    flags_in  = fl;
    int_req   = 1'b1;
    lat       = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      int_req = 1'b0;
      rti_in  = 1'b0;
      lat++;
      @(negedge clk);
      if (lat == 2) drain_sig = {busy_out, stall_fetch_out, stall_CCR_POP_out};
      if (mem_write_out) begin
        writes_seen++;
        if (pulse_rti && writes_seen == 2) rti_in = 1'b1;
      end
      if (PC_load_out) begin
        pc_val  = PC_load_val_out;
        fl_seen = flush_out;
        done    = 1;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!busy_out) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy_out still %0b after 30 cycles, expected 0", tag, busy_out);
    end
  endtask

  task automatic check_pushes(input string tag, input int start,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] exp_w [3];
    exp_w[0] = e0;
    exp_w[1] = e1;
    exp_w[2] = e2;
    checks++;
    if (push_log.size() - start !== 3) begin
      errors++;
      $display("FAIL %s_push_count: got %0d expected 3", tag, push_log.size() - start);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (push_log[start+k] !== exp_w[k]) begin
          errors++;
          $display("FAIL %s_push%0d: got %h expected %h", tag, k, push_log[start+k], exp_w[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    reset = 1'b1;
    @(negedge clk);
    ret_pc_in = 32'h0000_1234;
    flags_in  = 4'b0101;
    int_req   = 1'b1;
    @(posedge clk);
    #1;
    int_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_drain_entered: busy_out got %0b expected 1", busy_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_async_mid_drain: got %h expected 0", all_out);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_release_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_interrupt();
    int          lat;
    logic [31:0] pc_val;
    logic        fl;
    logic [2:0]  ds;
    int          start;
    start = push_log.size();
    run_int(32'h0000_1234, 4'b0101, 1'b0, lat, pc_val, fl, ds);
    checks++;
    if (lat !== INT_LAT) begin
      errors++;
      $display("FAIL int_latency: got %0d expected %0d", lat, INT_LAT);
    end
    checks++;
    if (pc_val !== 32'h0001_0200) begin
      errors++;
      $display("FAIL int_pc_load_val: got %h expected 00010200", pc_val);
    end
    checks++;
    if (fl !== 1'b1) begin
      errors++;
      $display("FAIL int_flush: got %0b expected 1", fl);
    end
    checks++;
    if (ds !== 3'b111) begin
      errors++;
      $display("FAIL int_drain_stalls: got %b expected 111", ds);
    end
    check_pushes("int", start, 16'h0000, 16'h1234, 16'h0005);
    @(negedge clk);
    checks++;
    if ({busy_out, PC_load_out, flush_out} !== 3'b000) begin
      errors++;
      $display("FAIL int_after_jump: busy/pc_load/flush got %b expected 000",
               {busy_out, PC_load_out, flush_out});
    end
  endtask

  task automatic test_rti();
    int          n, pops;
    logic [3:0]  popval;
    logic        ccr_during;
    logic [4:0]  rf_sig;
    logic [31:0] pc_val;
    logic        fl;
    bit          done;
    n = 1; pops = 0; popval = '0; ccr_during = 1'b1; rf_sig = '0; pc_val = '0; fl = 1'b0; done = 0;
    @(negedge clk);
    rti_in = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      rti_in = 1'b0;
      n++;
      @(negedge clk);
      if (n == 2) rf_sig = {mem_read_out, SP_src_out, stall_fetch_out, stall_CCR_POP_out};
      if (is_POP_flags_out) begin
        pops++;
        popval     = POP_flags_val_out;
        ccr_during = stall_CCR_POP_out;
      end
      if (PC_load_out) begin
        pc_val = PC_load_val_out;
        fl     = flush_out;
        done   = 1;
      end
    end
    checks++;
    if (n !== 5 || !done) begin
      errors++;
      $display("FAIL rti_latency: got %0d expected 5 (done=%0b)", n, done);
    end
    checks++;
    if (rf_sig !== 5'b1_10_1_1) begin
      errors++;
      $display("FAIL rti_r_flags_outputs: got %b expected 11011", rf_sig);
    end
    checks++;
    if (pops !== 1 || popval !== 4'b0101) begin
      errors++;
      $display("FAIL rti_pop_flags: got %0d pulses val %b expected 1 pulse val 0101", pops, popval);
    end
    checks++;
    if (ccr_during !== 1'b0) begin
      errors++;
      $display("FAIL rti_ccr_release: got %0b expected 0", ccr_during);
    end
    checks++;
    if (pc_val !== 32'h0000_1234 || fl !== 1'b1) begin
      errors++;
      $display("FAIL rti_pc_restore: got %h flush %0b expected 00001234 flush 1", pc_val, fl);
    end
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0 || sp !== 16) begin
      errors++;
      $display("FAIL rti_done: busy %0b sp %0d expected busy 0 sp 16", busy_out, sp);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    int_req = 1'b1;
    rti_in  = 1'b1;
    @(posedge clk);
    #1;
    int_req = 1'b0;
    rti_in  = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_read_out, SP_src_out, mem_write_out} !== 4'b1_10_0) begin
      errors++;
      $display("FAIL priority_rti_first: read/sp_src/write got %b expected 1100",
               {mem_read_out, SP_src_out, mem_write_out});
    end
    wait_idle("priority");
  endtask

  task automatic test_deferral();
    @(negedge clk);
    ret_pc_in = 32'h0000_0042;
    flags_in  = 4'b0011;
    int_req   = 1'b1;
    do_jmp_in = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL defer_jmp_blocks: busy got %0b expected 0", busy_out);
    end
    do_jmp_in = 1'b0;
    @(posedge clk);
    #1;
    int_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_out, mem_write_out, mem_read_out} !== 3'b100) begin
      errors++;
      $display("FAIL defer_accept_next: busy/write/read got %b expected 100",
               {busy_out, mem_write_out, mem_read_out});
    end
    wait_idle("defer");
  endtask

  task automatic test_busy_ignore();
    int          lat;
    logic [31:0] pc_val;
    logic        fl;
    logic [2:0]  ds;
    int          start;
    start = push_log.size();
    run_int(32'hFABC_DEF0, 4'b1010, 1'b1, lat, pc_val, fl, ds);
    checks++;
    if (lat !== INT_LAT || pc_val !== 32'h0001_0200) begin
      errors++;
      $display("FAIL busy_sequence: lat %0d pc %h expected %0d 00010200", lat, pc_val, INT_LAT);
    end
    check_pushes("busy", start, 16'h0ABC, 16'hDEF0, 16'h000A);
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop_after_jump: got %0b expected 0", busy_out);
    end
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0 || mem_read_out !== 1'b0) begin
      errors++;
      $display("FAIL busy_rti_not_queued: busy %0b read %0b expected 0 0", busy_out, mem_read_out);
    end
  endtask

  task automatic test_wrap();
    int          lat;
    logic [31:0] pc_val;
    logic        fl;
    logic [2:0]  ds;
    int          start, astart;
    start  = push_log.size();
    astart = rd_addr_w.size();
    run_int(32'h0765_4321, 4'b1000, 1'b0, lat, pc_val, fl, ds);
    check_pushes("wrap", start, 16'h0765, 16'h4321, 16'h0008);
    checks++;
    if (rd_addr_w.size() - astart !== 2) begin
      errors++;
      $display("FAIL wrap_vec_reads: got %0d reads expected 2", rd_addr_w.size() - astart);
    end else begin
      checks++;
      if (rd_addr_w[astart] !== 16'hFFFF || rd_addr_w[astart+1] !== 16'h0000) begin
        errors++;
        $display("FAIL wrap_vec_addr: got %h,%h expected ffff,0000",
                 rd_addr_w[astart], rd_addr_w[astart+1]);
      end
    end
    wait_idle("wrap");
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_rti();
    test_priority();
    test_deferral();
    test_busy_ignore();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
